// File: rtl/rep_hist.sv
// History-stack controller for the repetition detector: owns the history RAM
// write port and depth, and wraps the detector handshake in a valid/ready query port.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module rep_hist #(
    parameter int REPDET_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_push,
    input  logic                      cmd_pop,
    input  logic                      cmd_mark,
    input  logic                      cmd_trunc,
    input  logic [`BOARD_WIDTH-1:0]   push_board,
    input  logic [3:0]                push_castle_mask,
    output logic                      cmd_ready,
    input  logic                      query_valid,
    input  logic [`BOARD_WIDTH-1:0]   query_board,
    input  logic [3:0]                query_castle_mask,
    output logic                      query_ready,
    output logic                      result_valid,
    output logic                      result_rep,
    output logic [REPDET_WIDTH-1:0]   depth,
    output logic                      err_overflow,
    output logic                      err_underflow,
    output logic                      err_multi,
    output logic [`BOARD_WIDTH-1:0]   rd_board,
    output logic [3:0]                rd_castle_mask,
    output logic                      rd_board_valid,
    output logic                      rd_clear_sample,
    output logic [`BOARD_WIDTH-1:0]   rd_ram_board,
    output logic [3:0]                rd_ram_castle_mask,
    output logic [REPDET_WIDTH-1:0]   rd_ram_wr_addr,
    output logic [REPDET_WIDTH-1:0]   rd_ram_depth,
    output logic                      rd_ram_wr_en,
    input  logic                      rd_thrice_rep,
    input  logic                      rd_thrice_rep_valid
);

    // state | meaning
    // IDLE  | accepting commands and queries
    // ISSUE | board_valid pulse to the detector
    // WAIT  | waiting for the detector verdict
    // CLEAR | clear_sample + result_valid pulse
    // DRAIN | waiting for the detector's lingering valid to drop
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CLEAR = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [REPDET_WIDTH-1:0] DEPTH_MAX = {REPDET_WIDTH{1'b1}};
    localparam logic [REPDET_WIDTH-1:0] ONE       = REPDET_WIDTH'(1);

    state_t                    state_q, state_d;
    logic [REPDET_WIDTH-1:0]   depth_q, depth_d;
    logic [REPDET_WIDTH-1:0]   game_len_q, game_len_d;
    logic                      err_overflow_q, err_overflow_d;
    logic                      err_underflow_q, err_underflow_d;
    logic                      err_multi_q, err_multi_d;
    logic                      wr_en_q, wr_en_d;
    logic [REPDET_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [`BOARD_WIDTH-1:0]   ram_board_q, ram_board_d;
    logic [3:0]                ram_mask_q, ram_mask_d;
    logic [`BOARD_WIDTH-1:0]   q_board_q, q_board_d;
    logic [3:0]                q_mask_q, q_mask_d;
    logic                      rep_q, rep_d;

    logic [2:0]                n_cmd;
    logic [REPDET_WIDTH-1:0]   depth_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            depth_q         <= '0;
            game_len_q      <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_multi_q     <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            ram_board_q     <= '0;
            ram_mask_q      <= '0;
            q_board_q       <= '0;
            q_mask_q        <= '0;
            rep_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            depth_q         <= depth_d;
            game_len_q      <= game_len_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
            err_multi_q     <= err_multi_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            ram_board_q     <= ram_board_d;
            ram_mask_q      <= ram_mask_d;
            q_board_q       <= q_board_d;
            q_mask_q        <= q_mask_d;
            rep_q           <= rep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (query_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (rd_thrice_rep_valid) state_d = CLEAR;
            CLEAR:   state_d = DRAIN;
            DRAIN:   if (!rd_thrice_rep_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // History commands, query latch and verdict capture.
    always_comb begin
        depth_d         = depth_q;
        game_len_d      = game_len_q;
        err_overflow_d  = err_overflow_q;
        err_underflow_d = err_underflow_q;
        err_multi_d     = err_multi_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        ram_board_d     = ram_board_q;
        ram_mask_d      = ram_mask_q;
        q_board_d       = q_board_q;
        q_mask_d        = q_mask_q;
        rep_d           = rep_q;
        n_cmd           = {2'b00, cmd_push} + {2'b00, cmd_pop}
                        + {2'b00, cmd_mark} + {2'b00, cmd_trunc};
        depth_dec       = depth_q - ONE;

        if (state_q == IDLE) begin
            if (n_cmd > 3'd1) err_multi_d = 1'b1;
            if (cmd_trunc) begin
                depth_d = game_len_q;
            end else if (cmd_pop) begin
                if (depth_q == '0) begin
                    err_underflow_d = 1'b1;
                end else begin
                    depth_d = depth_dec;
                    if (depth_dec < game_len_q) game_len_d = depth_dec;
                end
            end else if (cmd_push) begin
                if (depth_q == DEPTH_MAX) begin
                    err_overflow_d = 1'b1;
                end else begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = depth_q;
                    ram_board_d = push_board;
                    ram_mask_d  = push_castle_mask;
                    depth_d     = depth_q + ONE;
                end
            end else if (cmd_mark) begin
                game_len_d = depth_q;
            end
            if (query_valid) begin
                q_board_d = query_board;
                q_mask_d  = query_castle_mask;
            end
        end

        if (state_q == WAIT && rd_thrice_rep_valid) rep_d = rd_thrice_rep;
    end

    always_comb begin
        cmd_ready          = (state_q == IDLE);
        query_ready        = (state_q == IDLE);
        rd_board_valid     = (state_q == ISSUE);
        rd_clear_sample    = (state_q == CLEAR);
        result_valid       = (state_q == CLEAR);
        result_rep         = (state_q == CLEAR) ? rep_q : 1'b0;
        depth              = depth_q;
        rd_ram_depth       = depth_q;
        err_overflow       = err_overflow_q;
        err_underflow      = err_underflow_q;
        err_multi          = err_multi_q;
        rd_board           = q_board_q;
        rd_castle_mask     = q_mask_q;
        rd_ram_board       = ram_board_q;
        rd_ram_castle_mask = ram_mask_q;
        rd_ram_wr_addr     = wr_addr_q;
        rd_ram_wr_en       = wr_en_q;
    end

endmodule

// File: tb/tb_rep_hist.sv
// Randomized bench for rep_hist: a behavioural detector stands in for the real one,
// and a queue-based history model supplies every expected value.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_rep_hist;
    localparam int W  = 8;
    localparam int BW = `BOARD_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_push, cmd_pop, cmd_mark, cmd_trunc;
    logic [BW-1:0] push_board, query_board;
    logic [3:0]    push_castle_mask, query_castle_mask;
    logic          query_valid;
    logic          cmd_ready, query_ready, result_valid, result_rep;
    logic [W-1:0]  depth, rd_ram_wr_addr, rd_ram_depth;
    logic          err_overflow, err_underflow, err_multi;
    logic [BW-1:0] rd_board, rd_ram_board;
    logic [3:0]    rd_castle_mask, rd_ram_castle_mask;
    logic          rd_board_valid, rd_clear_sample, rd_ram_wr_en;
    logic          rd_thrice_rep, rd_thrice_rep_valid;

    rep_hist #(.REPDET_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .cmd_push(cmd_push), .cmd_pop(cmd_pop), .cmd_mark(cmd_mark), .cmd_trunc(cmd_trunc),
        .push_board(push_board), .push_castle_mask(push_castle_mask),
        .cmd_ready(cmd_ready),
        .query_valid(query_valid), .query_board(query_board),
        .query_castle_mask(query_castle_mask), .query_ready(query_ready),
        .result_valid(result_valid), .result_rep(result_rep), .depth(depth),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_multi(err_multi),
        .rd_board(rd_board), .rd_castle_mask(rd_castle_mask),
        .rd_board_valid(rd_board_valid), .rd_clear_sample(rd_clear_sample),
        .rd_ram_board(rd_ram_board), .rd_ram_castle_mask(rd_ram_castle_mask),
        .rd_ram_wr_addr(rd_ram_wr_addr), .rd_ram_depth(rd_ram_depth),
        .rd_ram_wr_en(rd_ram_wr_en),
        .rd_thrice_rep(rd_thrice_rep), .rd_thrice_rep_valid(rd_thrice_rep_valid)
    );

    always #5 clk = ~clk;

    // Detector stand-in: verdict 2 cycles after board_valid for depth<2, else 2*depth+2;
    // thrice = at least three stored entries equal the queried position.
    logic [BW+3:0] det_ram [0:255];
    int            det_timer;
    int            det_depth;
    logic [BW+3:0] det_key;
    logic          det_valid, det_rep, det_clr_pend;
    assign rd_thrice_rep_valid = det_valid;
    assign rd_thrice_rep       = det_rep;

    function automatic logic det_verdict(input logic [BW+3:0] key, input int d);
        int c = 0;
        for (int i = 0; i < d; i++) if (det_ram[i] == key) c++;
        return (d >= 2) && (c >= 3);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            det_timer    <= 0;
            det_valid    <= 1'b0;
            det_rep      <= 1'b0;
            det_clr_pend <= 1'b0;
        end else begin
            if (rd_ram_wr_en) det_ram[rd_ram_wr_addr] <= {rd_ram_castle_mask, rd_ram_board};
            if (rd_board_valid) begin
                det_timer <= (int'(rd_ram_depth) < 2) ? 1 : 2 * int'(rd_ram_depth) + 1;
                det_depth <= int'(rd_ram_depth);
                det_key   <= {rd_castle_mask, rd_board};
            end else if (det_timer > 0) begin
                det_timer <= det_timer - 1;
                if (det_timer == 1) begin
                    det_valid <= 1'b1;
                    det_rep   <= det_verdict(det_key, det_depth);
                end
            end
            det_clr_pend <= rd_clear_sample;
            if (det_clr_pend) begin
                det_valid <= 1'b0;
                det_rep   <= 1'b0;
            end
        end
    end

    // Reference model of the history stack.
    logic [BW+3:0] hist[$];
    int            glen;
    bit            e_over, e_under, e_multi, exp_wr;
    int            exp_addr;
    int            n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        hist.delete();
        glen = 0; e_over = 0; e_under = 0; e_multi = 0; exp_wr = 0; exp_addr = 0;
    endtask

    task automatic model_cmd(input bit p, input bit po, input bit m, input bit t,
                             input logic [BW-1:0] b, input logic [3:0] mk);
        exp_wr = 0;
        if (int'(p) + int'(po) + int'(m) + int'(t) > 1) e_multi = 1;
        if (t) begin
            while (hist.size() > glen) void'(hist.pop_back());
        end else if (po) begin
            if (hist.size() == 0) e_under = 1;
            else begin
                void'(hist.pop_back());
                if (hist.size() < glen) glen = hist.size();
            end
        end else if (p) begin
            if (hist.size() == 255) e_over = 1;
            else begin
                exp_wr = 1; exp_addr = hist.size();
                hist.push_back({mk, b});
            end
        end else if (m) begin
            glen = hist.size();
        end
    endtask

    function automatic bit model_rep(input logic [BW+3:0] key);
        int c = 0;
        foreach (hist[i]) if (hist[i] == key) c++;
        return (hist.size() >= 2) && (c >= 3);
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".depth"}, depth, hist.size());
        check({tag, ".ovf"}, err_overflow, e_over);
        check({tag, ".unf"}, err_underflow, e_under);
        check({tag, ".multi"}, err_multi, e_multi);
    endtask

    task automatic clear_inputs();
        cmd_push = 0; cmd_pop = 0; cmd_mark = 0; cmd_trunc = 0; query_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1; clear_inputs();
        @(negedge clk); @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cmd_ready"}, cmd_ready, 1);
        check({tag, ".query_ready"}, query_ready, 1);
        check({tag, ".outs"}, {result_valid, result_rep, rd_board_valid, rd_clear_sample,
              rd_ram_wr_en, err_overflow, err_underflow, err_multi}, 8'h00);
        check({tag, ".depth"}, {depth, rd_ram_depth, rd_ram_wr_addr}, 24'h0);
        check({tag, ".rd_board"}, {rd_board, rd_castle_mask, rd_ram_board, rd_ram_castle_mask}, 0);
    endtask

    // Called at a negedge; returns at the negedge after the command edge.
    task automatic do_cmd(input string tag, input bit p, input bit po, input bit m, input bit t,
                          input logic [BW-1:0] b, input logic [3:0] mk);
        check({tag, ".cmd_ready"}, cmd_ready, 1);
        cmd_push = p; cmd_pop = po; cmd_mark = m; cmd_trunc = t;
        push_board = b; push_castle_mask = mk;
        model_cmd(p, po, m, t, b, mk);
        @(negedge clk);
        clear_inputs();
        check({tag, ".wr_en"}, rd_ram_wr_en, exp_wr);
        if (exp_wr) check({tag, ".wr_data"}, {rd_ram_wr_addr, rd_ram_castle_mask, rd_ram_board},
                          {exp_addr[W-1:0], hist[exp_addr]});
        check_state(tag);
    endtask

    // Query with optional same-cycle push, optional command during WAIT,
    // optional reset at a given cycle (0 = none).
    task automatic do_query(input string tag, input logic [BW-1:0] b, input logic [3:0] mk,
                            input bit acc_push, input logic [BW-1:0] pb, input logic [3:0] pm,
                            input bit wait_cmd, input int rst_at);
        int d, exp_r, cyc, res_cyc, pulses, ready_cyc;
        bit erep, got;
        check({tag, ".ready0"}, query_ready, 1);
        query_valid = 1; query_board = b; query_castle_mask = mk;
        if (acc_push) begin
            cmd_push = 1; push_board = pb; push_castle_mask = pm;
            model_cmd(1, 0, 0, 0, pb, pm);
        end
        d = hist.size();
        exp_r = (d < 2) ? 4 : 2 * d + 4;
        erep = model_rep({mk, b});
        cyc = 0; res_cyc = -1; pulses = 0; ready_cyc = -1; got = 0;
        while (cyc < exp_r + 20) begin
            @(negedge clk);
            cyc++;
            clear_inputs();
            reset = 0;
            if (cyc == 1) begin
                check({tag, ".issue"}, {rd_board_valid, query_ready}, 2'b10);
                check({tag, ".rd_board"}, {rd_castle_mask, rd_board}, {mk, b});
                if (acc_push) check({tag, ".acc_wr"}, rd_ram_wr_en, 1);
            end
            if (rst_at > 0 && cyc == rst_at) begin
                reset = 1;
                @(negedge clk);
                reset = 0;
                model_reset();
                check_reset_outputs({tag, ".rst"});
                return;
            end
            if (wait_cmd && cyc == 3) begin
                cmd_push = 1; push_board = {$urandom, $urandom}; push_castle_mask = 4'hF;
            end
            if (result_valid) begin
                pulses++;
                if (res_cyc < 0) begin res_cyc = cyc; got = result_rep; end
                check({tag, ".clear"}, rd_clear_sample, 1);
            end
            if (query_ready) begin ready_cyc = cyc; break; end
        end
        check({tag, ".res_cyc"}, res_cyc, exp_r);
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".rep"}, got, erep);
        check({tag, ".ready_cyc"}, ready_cyc, exp_r + 3);
        check_state(tag);
    endtask

    logic [BW-1:0] bank_b [3];
    logic [3:0]    bank_m [3];
    logic [BW-1:0] ba, bb;

    initial begin
        reset = 1; clear_inputs();
        push_board = '0; push_castle_mask = '0; query_board = '0; query_castle_mask = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset");
        reset = 0;

        ba = {$urandom, $urandom}; bb = {$urandom, $urandom};
        do_cmd("pA0", 1, 0, 0, 0, ba, 4'h3);
        do_cmd("pB0", 1, 0, 0, 0, bb, 4'h3);
        do_cmd("pA1", 1, 0, 0, 0, ba, 4'h3);
        do_cmd("pB1", 1, 0, 0, 0, bb, 4'h3);
        do_query("qA4", ba, 4'h3, 0, '0, '0, 0, 0);
        do_cmd("pA2", 1, 0, 0, 0, ba, 4'h3);
        do_query("qA5", ba, 4'h3, 0, '0, '0, 0, 0);
        do_query("qAmask", ba, 4'h1, 0, '0, '0, 0, 0);

        do_reset();
        do_query("q_d0", ba, 4'h3, 0, '0, '0, 0, 0);
        do_cmd("p_d1", 1, 0, 0, 0, ba, 4'h3);
        do_query("q_d1", ba, 4'h3, 0, '0, '0, 0, 0);
        do_query("q_accpush", ba, 4'h3, 1, ba, 4'h3, 0, 0);

        do_reset();
        for (int i = 0; i < 3; i++) do_cmd("g_push", 1, 0, 0, 0, {$urandom, $urandom}, 4'h5);
        do_cmd("mark", 0, 0, 1, 0, '0, '0);
        for (int i = 0; i < 4; i++) do_cmd("s_push", 1, 0, 0, 0, {$urandom, $urandom}, 4'h5);
        do_cmd("trunc", 0, 0, 0, 1, '0, '0);
        for (int i = 0; i < 4; i++) do_cmd("pop", 0, 1, 0, 0, '0, '0);
        do_cmd("p_after", 1, 0, 0, 0, ba, 4'h0);
        do_cmd("trunc0", 0, 0, 0, 1, '0, '0);

        do_reset();
        do_cmd("p_one", 1, 0, 0, 0, ba, 4'h2);
        do_cmd("push_pop", 1, 1, 0, 0, bb, 4'h2);
        do_cmd("p_two", 1, 0, 0, 0, bb, 4'h2);
        do_query("q_waitcmd", bb, 4'h2, 0, '0, '0, 1, 0);

        do_reset();
        for (int i = 0; i < 3; i++) do_cmd("r_push", 1, 0, 0, 0, ba, 4'h1);
        do_query("q_rst", ba, 4'h1, 0, '0, '0, 0, 4);
        do_query("q_post_rst", ba, 4'h1, 1, ba, 4'h1, 0, 0);

        for (int i = 0; i < 3; i++) begin
            bank_b[i] = {$urandom, $urandom};
            bank_m[i] = 4'($urandom_range(0, 15));
        end
        for (int n = 0; n < 80; n++) begin
            int r, k;
            logic [3:0] bits;
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 2);
            bits = 4'($urandom_range(0, 15));
            case (r)
                0, 1, 2, 3: do_cmd("rnd_push", 1, 0, 0, 0, bank_b[k], bank_m[k]);
                4, 5:       do_cmd("rnd_pop", 0, 1, 0, 0, '0, '0);
                6:          do_cmd("rnd_mark", 0, 0, 1, 0, '0, '0);
                7:          do_cmd("rnd_trunc", 0, 0, 0, 1, '0, '0);
                8:          do_cmd("rnd_multi", bits[0], bits[1], bits[2], bits[3], bank_b[k], bank_m[k]);
                default:    do_query("rnd_q", bank_b[k], bank_m[k], 1'($urandom_range(0, 1)),
                                     bank_b[(k + 1) % 3], bank_m[(k + 1) % 3],
                                     1'($urandom_range(0, 1)), 0);
            endcase
        end

        do_reset();
        for (int i = 0; i < 255; i++) do_cmd("fill", 1, 0, 0, 0, bank_b[i % 3], bank_m[i % 3]);
        do_cmd("overflow", 1, 0, 0, 0, ba, 4'h0);
        do_query("q_full", bank_b[0], bank_m[0], 0, '0, '0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
